// File: rtl/detector_sequencer.sv
// detector_sequencer: plays a latched pattern into the one-hot and binary
// sequence detectors and scores their z outputs against each other.
module detector_sequencer #(
   parameter int LEN = 16,
   parameter int IW  = $clog2(LEN),
   parameter int CW  = $clog2(LEN + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           abort,
   input  logic [LEN-1:0] pattern,
   input  logic           z_onehot,
   input  logic           z_binary,
   output logic           w,
   output logic           fsm_en,
   output logic           fsm_clr,
   output logic           busy,
   output logic           done,
   output logic           mismatch,
   output logic [IW-1:0]  mismatch_idx,
   output logic [CW-1:0]  hit_count
);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   localparam logic [IW-1:0] LAST = IW'(LEN - 1);
   localparam logic [CW-1:0] SAT  = CW'(LEN);

   state_t         state;
   logic [LEN-1:0] pat;
   logic [IW-1:0]  idx;
   logic           smp;
   logic           diff;
   logic           kill;
   logic [IW-1:0]  smp_k;

   assign fsm_en = (state == RUN);
   assign w      = fsm_en & pat[idx];
   assign diff   = z_onehot ^ z_binary;
   assign kill   = abort && (state inside {CLEAR, RUN, DRAIN});

   // z for bit k shows up one cycle after bit k is played
   assign smp   = ((state == RUN) && (idx != '0)) || (state == DRAIN);
   assign smp_k = (state == DRAIN) ? LAST : idx - IW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pat          <= '0;
         idx          <= '0;
         fsm_clr      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         mismatch     <= 1'b0;
         mismatch_idx <= '0;
         hit_count    <= '0;
      end else begin
         fsm_clr <= 1'b0;
         done    <= 1'b0;
         if (kill) begin
            state   <= IDLE;
            busy    <= 1'b0;
            fsm_clr <= 1'b1;
         end else begin
            if (smp) begin
               if (diff && !mismatch)
                  mismatch_idx <= smp_k;
               if (diff)
                  mismatch <= 1'b1;
               if (z_onehot && hit_count != SAT)
                  hit_count <= hit_count + CW'(1);
            end
            unique case (state)
               IDLE: begin
                  if (start) begin
                     pat          <= pattern;
                     idx          <= '0;
                     hit_count    <= '0;
                     mismatch     <= 1'b0;
                     mismatch_idx <= '0;
                     fsm_clr      <= 1'b1;
                     busy         <= 1'b1;
                     state        <= CLEAR;
                  end
               end
               CLEAR: state <= RUN;
               RUN: begin
                  idx <= idx + IW'(1);
                  if (idx == LAST)
                     state <= DRAIN;
               end
               DRAIN: begin
                  done  <= 1'b1;
                  state <= DONE;
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_detector_sequencer.sv
// tb_detector_sequencer: directed runs with a detector stub; a monitor
// scores w bits and end-of-run results against queued expectations.
module tb_detector_sequencer;

   localparam int LEN = 16;
   localparam int IW  = 4;
   localparam int CW  = 5;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [LEN-1:0] pattern = '0;
   logic           z_onehot, z_binary;
   logic           w, fsm_en, fsm_clr, busy, done, mismatch;
   logic [IW-1:0]  mismatch_idx;
   logic [CW-1:0]  hit_count;

   typedef struct {
      int hit;
      int mis;
      int midx;
      int dcyc;
   } res_t;

   res_t rq[$];
   bit   wq[$];
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   int   done_cnt = 0;

   logic           zq;
   int             bcnt;
   logic           force_one = 1'b0;
   logic [LEN-1:0] inj = '0;

   detector_sequencer #(.LEN(LEN)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .pattern(pattern),
      .z_onehot(z_onehot),
      .z_binary(z_binary),
      .w(w),
      .fsm_en(fsm_en),
      .fsm_clr(fsm_clr),
      .busy(busy),
      .done(done),
      .mismatch(mismatch),
      .mismatch_idx(mismatch_idx),
      .hit_count(hit_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // detector stub: z is w delayed one enabled cycle
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         zq   <= 1'b0;
         bcnt <= 0;
      end else if (fsm_clr) begin
         zq   <= 1'b0;
         bcnt <= 0;
      end else if (fsm_en) begin
         zq   <= w;
         bcnt <= bcnt + 1;
      end
   end

   assign z_onehot = force_one | zq;
   assign z_binary = z_onehot ^ ((bcnt > 0) ? inj[bcnt-1] : 1'b0);

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_w(input logic [LEN-1:0] p, input int n);
      for (int i = 0; i < n; i++)
         wq.push_back(p[i]);
   endtask

   task automatic launch(input logic [LEN-1:0] p, output int e0);
      @(negedge clk);
      pattern = p;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      start = 1'b0;
   endtask

   task automatic exp_res(input int h, input int m, input int mi, input int dc);
      res_t r;
      r.hit = h;
      r.mis = m;
      r.midx = mi;
      r.dcyc = dc;
      rq.push_back(r);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done)
            seen = 1'b1;
      end
      chk("done_seen", int'(seen), 1);
   endtask

   // monitor
   always @(negedge clk) begin
      bit   b;
      res_t r;
      if (reset) begin
         if (fsm_en) begin
            if (wq.size() == 0) begin
               chk("w_unexpected", 1, 0);
            end else begin
               b = wq.pop_front();
               chk("w_bit", int'(w), int'(b));
            end
         end
         if (done) begin
            done_cnt++;
            if (rq.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               r = rq.pop_front();
               chk("done_cycle", cyc, r.dcyc);
               chk("hit_count", int'(hit_count), r.hit);
               chk("mismatch", int'(mismatch), r.mis);
               chk("mismatch_idx", int'(mismatch_idx), r.midx);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int dc0;
      #2 reset = 1'b0;
      @(negedge clk);
      chk("rst_w", int'(w), 0);
      chk("rst_fsm_en", int'(fsm_en), 0);
      chk("rst_fsm_clr", int'(fsm_clr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mismatch", int'(mismatch), 0);
      chk("rst_mismatch_idx", int'(mismatch_idx), 0);
      chk("rst_hit_count", int'(hit_count), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // basic run
      push_w(16'hA5F0, LEN);
      launch(16'hA5F0, e0);
      exp_res(8, 0, 0, e0 + LEN + 2);
      chk("clear_fsm_clr", int'(fsm_clr), 1);
      chk("clear_fsm_en", int'(fsm_en), 0);
      chk("clear_busy", int'(busy), 1);
      wait_done(40);
      @(negedge clk);
      chk("hold_busy", int'(busy), 0);
      chk("hold_hit_count", int'(hit_count), 8);

      // first mismatch capture
      inj = '0;
      inj[3] = 1'b1;
      inj[9] = 1'b1;
      push_w(16'hA5F0, LEN);
      launch(16'hA5F0, e0);
      exp_res(8, 1, 3, e0 + LEN + 2);
      wait_done(40);

      // saturation, mismatch only in the final sample
      force_one = 1'b1;
      inj = '0;
      inj[15] = 1'b1;
      push_w(16'h1234, LEN);
      launch(16'h1234, e0);
      exp_res(16, 1, 15, e0 + LEN + 2);
      wait_done(40);
      @(negedge clk);
      force_one = 1'b0;
      inj = '0;

      // abort in RUN
      dc0 = done_cnt;
      push_w(16'h3C5A, 7);
      launch(16'h3C5A, e0);
      repeat (8) @(negedge clk);
      chk("pre_abort_fsm_en", int'(fsm_en), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_fsm_clr", int'(fsm_clr), 1);
      chk("abort_fsm_en", int'(fsm_en), 0);
      @(posedge clk);
      #1;
      chk("abort_clr_once", int'(fsm_clr), 0);
      repeat (25) @(negedge clk);
      chk("abort_no_done", done_cnt - dc0, 0);

      // start and abort together
      push_w(16'hFFFF, 3);
      launch(16'hFFFF, e0);
      repeat (4) @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      chk("sa_busy", int'(busy), 0);
      chk("sa_fsm_clr", int'(fsm_clr), 1);
      repeat (3) @(negedge clk);
      chk("sa_stays_idle", int'(busy), 0);

      // start while running is ignored
      push_w(16'h8001, LEN);
      launch(16'h8001, e0);
      exp_res(2, 0, 0, e0 + LEN + 2);
      repeat (6) @(negedge clk);
      start = 1'b1;
      pattern = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      pattern = '0;
      wait_done(40);

      // back-to-back with start held
      inj = '0;
      inj[4] = 1'b1;
      push_w(16'hFFFF, LEN);
      @(negedge clk);
      pattern = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      exp_res(16, 1, 4, e0 + LEN + 2);
      wait_done(40);
      inj = '0;
      pattern = 16'h0001;
      push_w(16'h0001, LEN);
      exp_res(1, 0, 0, e0 + 2 * (LEN + 4) - 2);
      @(posedge clk);
      #1;
      chk("b2b_gap_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("b2b_accept_cyc", cyc, e0 + LEN + 4);
      chk("b2b_clear_hit", int'(hit_count), 0);
      chk("b2b_clear_mis", int'(mismatch), 0);
      wait_done(40);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_end_idle", int'(busy), 0);

      // reset mid-run at idx 5
      push_w(16'hA5F0, 6);
      launch(16'hA5F0, e0);
      repeat (7) @(negedge clk);
      chk("pre_rst_w", int'(w), 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_w", int'(w), 0);
      chk("mid_rst_fsm_en", int'(fsm_en), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_hit", int'(hit_count), 0);
      chk("mid_rst_mis", int'(mismatch), 0);
      chk("mid_rst_midx", int'(mismatch_idx), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_fsm_en", int'(fsm_en), 0);

      repeat (3) @(negedge clk);
      chk("res_queue_empty", rq.size(), 0);
      chk("w_queue_empty", wq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/detector_sequencer.md
# detector_sequencer

Self-checking stimulus controller for the sequence-detector pair (one-hot and binary implementations of the same `w`-input detector). On `start` it latches a bit pattern and clears both detectors. It then plays the pattern one bit per cycle on the shared `w` line, comparing the two `z` outputs every step. When the run finishes it reports the `z` hit count and the first divergence. It sits between the board inputs and the two detector instances and owns their `w`, enable and clear signals.

## Interface
- `LEN`, default 16, number of pattern bits per run (≥2)
- `IW`, default clog2(`LEN`), step-index width
- `CW`, default clog2(`LEN`+1), hit-count width
- `clk`, in, 1, single system clock, rising edge
- `reset`, in, 1, asynchronous, active-low reset
- `start`, in, 1, begin a run; sampled only in IDLE
- `abort`, in, 1, terminate the run in progress
- `pattern`, in, `LEN`, stimulus bits; bit 0 is played first; latched on accepted `start`
- `z_onehot`, in, 1, Moore output of the one-hot detector
- `z_binary`, in, 1, Moore output of the binary detector
- `w`, out, 1, shared detector input
- `fsm_en`, out, 1, detector clock enable; detectors advance only when high
- `fsm_clr`, out, 1, synchronous clear to both detectors (forces state A)
- `busy`, out, 1, high in every state except IDLE
- `done`, out, 1, one-cycle pulse on completion
- `mismatch`, out, 1, sticky: the detectors disagreed at least once this run
- `mismatch_idx`, out, `IW`, index of the bit after which the first disagreement appeared
- `hit_count`, out, `CW`, number of compared steps with `z_onehot`=1

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches `pattern`, zeroes `idx`, `hit_count`, `mismatch` and `mismatch_idx`, then moves to CLEAR.
  - `abort` is ignored in IDLE.
- **CLEAR** (1 cycle): `fsm_clr`=1, `fsm_en`=0, then moves to RUN.
- **RUN** (`LEN` cycles):
  - `w` = `pattern[idx]` and `fsm_en`=1.
  - `idx` increments each cycle.
  - After `idx`=`LEN`-1 the block moves to DRAIN.
- **DRAIN** (1 cycle): `fsm_en`=0, `w`=0. The result of the final bit is sampled here.
- **DONE** (1 cycle): `done`=1, then moves to IDLE.
- **Compare:**
  - The result of bit k is sampled in the cycle after bit k is played, i.e. RUN steps 1..`LEN`-1 plus DRAIN. That gives `LEN` samples per run.
  - Each sample where `z_onehot`≠`z_binary`: sets `mismatch`. The first such sample also records `mismatch_idx` = k; later mismatches do not overwrite it.
  - Each sample where `z_onehot`=1: `hit_count` increments. It saturates at `LEN` and cannot overflow.
- **Results:** `hit_count`, `mismatch` and `mismatch_idx` hold after DONE until the next accepted `start`.
- **abort in CLEAR, RUN or DRAIN:**
  - Next cycle the block is in IDLE with `fsm_clr`=1 for that one cycle.
  - No `done` pulse.
  - Results hold their partial values.
- **Simultaneous events:**
  - `abort` and `start` together in a busy state: abort wins and `start` is dropped.
  - `start` while busy: ignored, with no re-latch of `pattern`.
- **Reset** (any time, including mid-run): state→IDLE and all outputs 0 immediately; `pattern` register→0.

## Timing
- Cycle 0 is the edge sampling `start`=1 in IDLE.
- Cycle 1: CLEAR.
- Cycles 2..`LEN`+1: RUN, with bit k on `w` in cycle k+2.
- Cycle `LEN`+2: DRAIN.
- Cycle `LEN`+3: DONE. `done`=1 and final results are valid in this cycle.
- Earliest next `start` is accepted in cycle `LEN`+4.
- `busy` is high in cycles 1..`LEN`+3.
- All outputs are registered (no combinational input→output paths), except that `w` and `fsm_en` decode directly from the state register and `idx`.
- Reset values: `w`=0, `fsm_en`=0, `fsm_clr`=0, `busy`=0, `done`=0, `mismatch`=0, `mismatch_idx`=0, `hit_count`=0.

## Test plan
- **Reset mid-run:** `LEN`=16; assert `reset`=0 during RUN at `idx`=5 → all outputs 0 in the same cycle; after release, the block idles until `start`.
- **Basic run:** `pattern`=16'hA5F0, bench ties `z_onehot`=`z_binary`=`w` delayed by one cycle → `w` sequence 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1 in cycles 2..17; `done` in cycle 19; `hit_count`=8; `mismatch`=0.
- **First-mismatch capture:** stub forces `z_binary`≠`z_onehot` at samples k=3 and k=9 → `mismatch`=1, `mismatch_idx`=3.
- **Saturation and final sample:** `z_onehot`=`z_binary`=1 held → `hit_count`=16 with no wrap; a mismatch injected only in DRAIN → `mismatch_idx`=15.
- **Abort and start conflicts:** `abort` at cycle 8 → IDLE next cycle, `fsm_clr` pulsed once, no `done`; `start`+`abort` together → abort wins; `start` pulsed in RUN → ignored and the run completes on schedule.
- **Back-to-back runs:** `start` held high continuously → runs begin every `LEN`+4 cycles; results clear at each new accept.
